ad7476a_sample_averager: RTL and testbench



---
 rtl/ad7476a_sample_averager_pkg.sv | 15 +
 rtl/ad7476a_sample_averager_sample_tick_gen.sv | 30 +++
 rtl/ad7476a_sample_averager.sv | 128 ++++++++++++
 tb/tb_ad7476a_sample_averager.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ad7476a_sample_averager_pkg.sv
// Shared constants and helpers for the AD7476A sample averager and its tick generator.
package ad7476a_sample_averager_pkg;

  localparam int AD7476A_SAMPLE_WIDTH = 12;

  // Device timing minima in ns: CS-to-SCLK setup and end-of-frame quiet time.
  localparam int T2_NS             = 10;
  localparam int T8_PLUS_TQUIET_NS = 86;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ad7476a_sample_averager_sample_tick_gen.sv
// Free-running 0..PERIOD-1 counter that emits a one-cycle tick on its last count.
module sample_tick_gen
  import ad7476a_sample_averager_pkg::*;
#(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = cnt_width(PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/ad7476a_sample_averager.sv
// Paces AD7476A conversion requests, boxcar-averages 2^LOG2_AVG samples per device
// and presents each average on a valid/ready output with a sticky overrun flag.
module ad7476a_sample_averager
  import ad7476a_sample_averager_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int SAMPLE_RATE_HZ = 1000000,
  parameter int NUM_DEVICES    = 1,
  parameter int SAMPLE_WIDTH   = AD7476A_SAMPLE_WIDTH,
  parameter int LOG2_AVG       = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  output logic                                request_o,
  input  logic [SAMPLE_WIDTH*NUM_DEVICES-1:0] adc_data_i,
  input  logic                                adc_valid_i,
  output logic [SAMPLE_WIDTH*NUM_DEVICES-1:0] avg_data_o,
  output logic                                avg_valid_o,
  input  logic                                avg_ready_i,
  output logic                                overrun_o,
  input  logic                                clear_overrun_i
);

  localparam int PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int AVG_N  = 1 << LOG2_AVG;
  localparam int CNT_W  = cnt_width(AVG_N);
  localparam int ACC_W  = SAMPLE_WIDTH + LOG2_AVG;
  localparam int BUS_W  = SAMPLE_WIDTH * NUM_DEVICES;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(AVG_N - 1);

  if (PERIOD < 2) begin : g_bad_period
    $error("PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ must be at least 2");
  end
  if (NUM_DEVICES < 1) begin : g_bad_devices
    $error("NUM_DEVICES must be at least 1");
  end
  if (LOG2_AVG < 0 || LOG2_AVG > 8) begin : g_bad_avg
    $error("LOG2_AVG must be in 0..8");
  end

  logic             tick;
  logic             pending_q;
  logic             missed_tick;
  logic             complete;
  logic             load;
  logic             drop;
  logic [CNT_W-1:0] count_q;
  logic [BUS_W-1:0] result;

  sample_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk    (clk_i),
    .rst    (rst_i),
    .enable (enable_i),
    .tick   (tick)
  );

  // A tick outranks the strobe so a request raised in the strobe cycle is not lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
    end else if (tick) begin
      pending_q <= 1'b1;
    end else if (adc_valid_i) begin
      pending_q <= 1'b0;
    end
  end

  // Masked by the strobe so the interface does not re-fire on an already-served request.
  assign request_o   = pending_q & ~adc_valid_i;
  assign missed_tick = tick & pending_q & ~adc_valid_i;
  assign complete    = adc_valid_i && (count_q == LAST_SAMPLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (adc_valid_i) begin
      count_q <= complete ? '0 : count_q + CNT_W'(1);
    end
  end

  for (genvar d = 0; d < NUM_DEVICES; d++) begin : g_dev
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;

    // Accumulator is wide enough for AVG_N full-scale samples, so the sum cannot wrap.
    assign sum = acc_q + ACC_W'(adc_data_i[SAMPLE_WIDTH*d +: SAMPLE_WIDTH]);
    assign result[SAMPLE_WIDTH*d +: SAMPLE_WIDTH] = sum[LOG2_AVG +: SAMPLE_WIDTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        acc_q <= '0;
      end else if (adc_valid_i) begin
        acc_q <= complete ? '0 : sum;
      end
    end
  end

  // Output handshake: a word transfers on a cycle with avg_valid_o & avg_ready_i; while
  // avg_valid_o is high avg_data_o is frozen and avg_valid_o only falls after a transfer.
  assign load = complete & (~avg_valid_o | avg_ready_i);
  assign drop = complete & avg_valid_o & ~avg_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avg_valid_o <= 1'b0;
      avg_data_o  <= '0;
    end else if (load) begin
      avg_valid_o <= 1'b1;
      avg_data_o  <= result;
    end else if (avg_ready_i) begin
      avg_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_o <= 1'b0;
    end else if (missed_tick || drop) begin
      overrun_o <= 1'b1;
    end else if (clear_overrun_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad7476a_sample_averager.sv
// Directed bench for ad7476a_sample_averager: two devices, PERIOD=100, 4-sample average.
module tb_ad7476a_sample_averager;

  localparam int SW = 12;
  localparam int ND = 2;
  localparam int W  = SW * ND;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         request_o;
  logic [W-1:0] adc_data_i;
  logic         adc_valid_i;
  logic [W-1:0] avg_data_o;
  logic         avg_valid_o;
  logic         avg_ready_i;
  logic         overrun_o;
  logic         clear_overrun_i;

  logic [W-1:0] exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  int           prev_rise   = 0;
  int           base        = 0;

  // Clock and cycle counter (counts rising edges; read on falling edges)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad7476a_sample_averager #(
    .CLK_FREQ_HZ    (100000000),
    .SAMPLE_RATE_HZ (1000000),
    .NUM_DEVICES    (ND),
    .SAMPLE_WIDTH   (SW),
    .LOG2_AVG       (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .request_o       (request_o),
    .adc_data_i      (adc_data_i),
    .adc_valid_i     (adc_valid_i),
    .avg_data_o      (avg_data_o),
    .avg_valid_o     (avg_valid_o),
    .avg_ready_i     (avg_ready_i),
    .overrun_o       (overrun_o),
    .clear_overrun_i (clear_overrun_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: inputs change on falling edges, so #1 later shows what the next rising edge samples
  always @(negedge clk) begin
    #1;
    if (avg_valid_o === 1'b1 && avg_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got 0x%0h expected no result (cycle %0d)", avg_data_o, cyc);
      end else begin
        check("avg_data", avg_data_o, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic start_run(input bit check_reset);
    @(negedge clk);
    rst_i           = 1'b1;
    enable_i        = 1'b1;
    adc_valid_i     = 1'b0;
    clear_overrun_i = 1'b0;
    repeat (2) @(negedge clk);
    if (check_reset) begin
      check("reset_request", request_o, 0);
      check("reset_avg_valid", avg_valid_o, 0);
      check("reset_avg_data", avg_data_o, 0);
      check("reset_overrun", overrun_o, 0);
    end
    rst_i     = 1'b0;
    prev_rise = cyc;
  endtask

  task automatic serve(input logic [W-1:0] d, input bit check_pulse);
    int n = 0;
    while (request_o !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (request_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL request_timeout: got request_o=0 expected 1 within 300 cycles");
      return;
    end
    check("request_period", cyc - prev_rise, 100);
    prev_rise = cyc;
    repeat (20) @(negedge clk);
    adc_data_i  = d;
    adc_valid_i = 1'b1;
    #1 check("request_drop", request_o, 0);
    @(negedge clk);
    adc_valid_i = 1'b0;
    if (check_pulse) begin
      check("pulse_on", avg_valid_o, 1);
      @(negedge clk);
      check("pulse_off", avg_valid_o, 0);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    rst_i           = 1'b1;
    enable_i        = 1'b0;
    adc_valid_i     = 1'b0;
    adc_data_i      = '0;
    avg_ready_i     = 1'b1;
    clear_overrun_i = 1'b0;

    // Reset values, then an incrementing set: dev0 0x406/4=0x101, dev1 0xA1/4=0x028
    start_run(1);
    serve({12'h010, 12'h100}, 0);
    serve({12'h020, 12'h101}, 0);
    serve({12'h030, 12'h102}, 0);
    exp_q.push_back({12'h028, 12'h101});
    serve({12'h041, 12'h103}, 1);

    // Full scale on dev0 must not wrap; dev1 1/4 truncates to 0
    serve({12'h001, 12'hFFF}, 0);
    serve({12'h000, 12'hFFF}, 0);
    serve({12'h000, 12'hFFF}, 0);
    exp_q.push_back({12'h000, 12'hFFF});
    serve({12'h000, 12'hFFF}, 1);

    // Requests never served: missed tick at 200, clear, set again at 300
    start_run(0);
    base = prev_rise;
    wait_until(base + 100);
    check("starved_request", request_o, 1);
    check("starved_overrun_100", overrun_o, 0);
    wait_until(base + 199);
    check("starved_overrun_199", overrun_o, 0);
    wait_until(base + 200);
    check("starved_overrun_200", overrun_o, 1);
    clear_overrun_i = 1'b1;
    @(negedge clk);
    clear_overrun_i = 1'b0;
    check("overrun_cleared", overrun_o, 0);
    wait_until(base + 299);
    check("starved_overrun_299", overrun_o, 0);
    wait_until(base + 300);
    check("starved_overrun_300", overrun_o, 1);
    check("starved_request_300", request_o, 1);

    // Consumer stalled across two averages: first held, second dropped
    avg_ready_i = 1'b0;
    start_run(0);
    exp_q.push_back({12'h010, 12'h010});
    repeat (4) serve({12'h010, 12'h010}, 0);
    check("held_valid", avg_valid_o, 1);
    check("held_no_overrun", overrun_o, 0);
    check("held_data", avg_data_o, {12'h010, 12'h010});
    repeat (4) serve({12'h020, 12'h020}, 0);
    check("drop_valid", avg_valid_o, 1);
    check("drop_data_kept", avg_data_o, {12'h010, 12'h010});
    check("drop_overrun", overrun_o, 1);
    @(negedge clk);
    avg_ready_i = 1'b1;
    @(negedge clk);
    avg_ready_i = 1'b0;
    check("accepted_valid_low", avg_valid_o, 0);

    // Reset mid-accumulation discards the partial sum
    avg_ready_i = 1'b1;
    start_run(0);
    serve({12'h7FF, 12'h7FF}, 0);
    serve({12'h7FF, 12'h7FF}, 0);
    start_run(1);
    exp_q.push_back({12'h200, 12'h200});
    repeat (3) serve({12'h200, 12'h200}, 0);
    serve({12'h200, 12'h200}, 1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
